fir_ctrl: RTL and testbench
===========================

# fir_ctrl

Block-level controller for the FIR accelerator: owns the ap_start/ap_done/ap_idle protocol and the data-length register, clears the data RAM before each run, and issues a one-cycle start pulse to the input stream block. It sequences the FIR datapath from start acceptance to last-output completion. It sits between the AXI-Lite config decoder and the FIR datapath (input stream block, tap/data RAMs, output stream).

## Interface
- pADDR_WIDTH, 12, RAM address width
- pDATA_WIDTH, 32, data/config word width
- Tape_Num, 11, number of taps = data RAM entries cleared per run

- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- ctrl_wr  in  1  write strobe to control reg (0x00)
- ctrl_wdata  in  pDATA_WIDTH  write data; bit0 = start request
- ctrl_rd  in  1  read strobe of control reg (clears ap_done)
- len_wr  in  1  write strobe to data-length reg (0x10)
- len_wdata  in  pDATA_WIDTH  data-length value
- axis_finish  in  1  input block accepted the tlast beat
- out_hs  in  1  output stream handshake (valid & ready)
- out_last  in  1  tlast of the output beat; qualified by out_hs
- ap_ctrl  out  4  {err, ap_idle, ap_done, ap_start_bit}
- data_length  out  pDATA_WIDTH  current length register
- out_cnt  out  pDATA_WIDTH  outputs delivered this run
- ap_start  out  1  one-cycle start pulse to the input stream block
- dram_clr_we  out  1  data RAM clear write enable
- dram_clr_addr  out  pADDR_WIDTH  clear byte address
- cfg_lock  out  1  1 = tap/length writes blocked (= ~ap_idle)

## Operation
- States: IDLE, CLEAR, RUN.
- IDLE: ctrl_wr & ctrl_wdata[0] → CLEAR. Same edge: ap_start_bit=1, ap_idle=0, out_cnt=0, err=0, in_done=0, clear counter=0.
- Start request while not IDLE: ignored, no state change.
- len_wr in IDLE loads data_length. In CLEAR/RUN it is ignored.
- CLEAR lasts exactly Tape_Num cycles, count k = 0..Tape_Num-1.
  - Each CLEAR cycle: dram_clr_we=1, dram_clr_addr = 4*k.
  - After k = Tape_Num-1 → RUN.
  - Same edge as the RUN transition: ap_start_bit=0 and ap_start=1 for exactly one cycle.
- RUN:
  - axis_finish sets sticky in_done.
  - Each out_hs increments out_cnt (wraps modulo 2^pDATA_WIDTH).
  - out_hs & out_last → IDLE. Same edge: ap_done=1, ap_idle=1.
  - err=1 at completion if (out_cnt+1) != data_length, or if in_done=0.
- ap_done is sticky. It clears on the edge after ctrl_rd. If set and ctrl_rd coincide, set wins.
- err holds until the next accepted start.
- cfg_lock = ~ap_idle, combinational from the register.
- No mid-run abort. Only rst_n aborts a run.

## Timing
- Reset values of outputs:
  - ap_ctrl = 4'b0100 (idle only); data_length = 0; out_cnt = 0.
  - ap_start = 0; dram_clr_we = 0; dram_clr_addr = 0; cfg_lock = 0.
  - State returns to IDLE.
- Reset asserted mid-CLEAR or mid-RUN: all of the above apply immediately (asynchronous). No partial clear is resumed.
- All outputs are registered except cfg_lock.
- Latency:
  - Start write edge to first dram_clr_we: 1 cycle.
  - ap_start pulse: cycle Tape_Num+1 after the write edge.
  - Final out_hs edge to ap_done=1 / ap_idle=1: 1 cycle (visible the next cycle).
- out_hs sampled in CLEAR or IDLE: ignored. axis_finish outside RUN: ignored.
- Back-to-back: a start written in the cycle after completion is accepted normally.

## Test plan
- Reset → ap_ctrl=4'b0100, ap_start=0, dram_clr_we=0. Write len=64, then start=1 → 11 clear writes at addresses 0x00..0x28, then exactly one ap_start pulse, ap_ctrl=4'b0000.
- Drive 64 out_hs beats, the last with out_last, after axis_finish → ap_ctrl=4'b0110, err=0, out_cnt=64. ctrl_rd → ap_done=0 next cycle.
- Length mismatch: len=64, out_last on beat 10 → ap_done=1, err=1, out_cnt=10.
- Write start and len=5 during RUN → no second ap_start, data_length stays 64, cfg_lock=1 throughout.
- ctrl_rd in the same cycle as the completing out_hs → ap_done=1 retained. Next ctrl_rd → ap_done=0.
- Assert rst_n at CLEAR k=5 → immediate idle outputs, dram_clr_we=0. New start → full 11-entry clear from address 0.

Source files
------------

// File: rtl/fir_ctrl.sv
// fir_ctrl: ap_start/ap_done/ap_idle protocol, length register, data RAM clear and run sequencing
module fir_ctrl #(
    parameter int pADDR_WIDTH = 12,
    parameter int pDATA_WIDTH = 32,
    parameter int Tape_Num    = 11
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   ctrl_wr,
    input  logic [pDATA_WIDTH-1:0] ctrl_wdata,
    input  logic                   ctrl_rd,
    input  logic                   len_wr,
    input  logic [pDATA_WIDTH-1:0] len_wdata,
    input  logic                   axis_finish,
    input  logic                   out_hs,
    input  logic                   out_last,
    output logic [3:0]             ap_ctrl,
    output logic [pDATA_WIDTH-1:0] data_length,
    output logic [pDATA_WIDTH-1:0] out_cnt,
    output logic                   ap_start,
    output logic                   dram_clr_we,
    output logic [pADDR_WIDTH-1:0] dram_clr_addr,
    output logic                   cfg_lock
);
    localparam int CW = $clog2(Tape_Num + 1);

    typedef enum logic [1:0] {IDLE, CLEAR, RUN} state_t;

    state_t                 state_q, state_d;
    logic [CW-1:0]          clr_cnt_q, clr_cnt_d;
    logic                   sbit_q, sbit_d;
    logic                   idle_q, idle_d;
    logic                   done_q, done_d;
    logic                   err_q, err_d;
    logic                   in_done_q, in_done_d;
    logic [pDATA_WIDTH-1:0] len_q, len_d;
    logic [pDATA_WIDTH-1:0] cnt_q, cnt_d;
    logic                   start_q, start_d;
    logic                   we_q, we_d;
    logic [pADDR_WIDTH-1:0] addr_q, addr_d;

    logic                   start_req;
    logic                   last_clr;
    logic [CW-1:0]          clr_nxt;
    logic [pDATA_WIDTH-1:0] cnt_inc;
    logic                   unused_wdata;

    assign start_req    = ctrl_wr & ctrl_wdata[0];
    assign last_clr     = clr_cnt_q == CW'(Tape_Num - 1);
    assign clr_nxt      = clr_cnt_q + 1'b1;
    assign cnt_inc      = cnt_q + pDATA_WIDTH'(1);
    assign unused_wdata = ^ctrl_wdata[pDATA_WIDTH-1:1];

    assign ap_ctrl       = {err_q, idle_q, done_q, sbit_q};
    assign data_length   = len_q;
    assign out_cnt       = cnt_q;
    assign ap_start      = start_q;
    assign dram_clr_we   = we_q;
    assign dram_clr_addr = addr_q;
    assign cfg_lock      = ~idle_q;

    // Next-state: accept start in IDLE, walk the clear addresses, then count outputs until tlast
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        sbit_d    = sbit_q;
        idle_d    = idle_q;
        done_d    = ctrl_rd ? 1'b0 : done_q;
        err_d     = err_q;
        in_done_d = in_done_q;
        len_d     = len_q;
        cnt_d     = cnt_q;
        start_d   = 1'b0;
        we_d      = 1'b0;
        addr_d    = '0;
        case (state_q)
            IDLE: begin
                if (len_wr) len_d = len_wdata;
                if (start_req) begin
                    state_d   = CLEAR;
                    sbit_d    = 1'b1;
                    idle_d    = 1'b0;
                    cnt_d     = '0;
                    err_d     = 1'b0;
                    in_done_d = 1'b0;
                    clr_cnt_d = '0;
                    we_d      = 1'b1;
                end
            end
            CLEAR: begin
                if (last_clr) begin
                    state_d = RUN;
                    sbit_d  = 1'b0;
                    start_d = 1'b1;
                end else begin
                    clr_cnt_d = clr_nxt;
                    we_d      = 1'b1;
                    addr_d    = pADDR_WIDTH'({clr_nxt, 2'b00});
                end
            end
            RUN: begin
                if (axis_finish) in_done_d = 1'b1;
                if (out_hs) begin
                    cnt_d = cnt_inc;
                    if (out_last) begin
                        state_d = IDLE;
                        idle_d  = 1'b1;
                        done_d  = 1'b1;
                        err_d   = (cnt_inc != len_q) | ~in_done_q;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers; reset aborts any clear or run immediately
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            clr_cnt_q <= '0;
            sbit_q    <= 1'b0;
            idle_q    <= 1'b1;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            in_done_q <= 1'b0;
            len_q     <= '0;
            cnt_q     <= '0;
            start_q   <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
            sbit_q    <= sbit_d;
            idle_q    <= idle_d;
            done_q    <= done_d;
            err_q     <= err_d;
            in_done_q <= in_done_d;
            len_q     <= len_d;
            cnt_q     <= cnt_d;
            start_q   <= start_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
        end
    end
endmodule

// File: tb/tb_fir_ctrl.sv
// tb_fir_ctrl: directed bench for fir_ctrl with a cycle-indexed reference model
module tb_fir_ctrl;
    localparam int TN = 11;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ctrl_wr, ctrl_rd, len_wr, axis_finish, out_hs, out_last;
    logic [31:0] ctrl_wdata, len_wdata;
    logic [3:0]  ap_ctrl;
    logic [31:0] data_length, out_cnt;
    logic        ap_start, dram_clr_we, cfg_lock;
    logic [11:0] dram_clr_addr;

    int passed = 0;
    int total  = 0;

    fir_ctrl #(.pADDR_WIDTH(12), .pDATA_WIDTH(32), .Tape_Num(TN)) dut (
        .clk(clk), .rst_n(rst_n),
        .ctrl_wr(ctrl_wr), .ctrl_wdata(ctrl_wdata), .ctrl_rd(ctrl_rd),
        .len_wr(len_wr), .len_wdata(len_wdata),
        .axis_finish(axis_finish), .out_hs(out_hs), .out_last(out_last),
        .ap_ctrl(ap_ctrl), .data_length(data_length), .out_cnt(out_cnt),
        .ap_start(ap_start), .dram_clr_we(dram_clr_we), .dram_clr_addr(dram_clr_addr),
        .cfg_lock(cfg_lock)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Model: t counts cycles since the accepted start (1..TN clear, TN+1 start pulse, RUN from TN+1)
    int          t = 0;
    logic        m_idle, m_done, m_err, m_sbit, m_start, m_we, m_in_done;
    logic [31:0] m_len, m_cnt;
    logic [11:0] m_addr;
    int          clr_seen = 0, start_seen = 0;
    logic [11:0] first_addr = '0, last_addr = '0;
    logic        we_prev = 1'b0;

    initial forever begin
        logic run, fin, in_old;
        @(negedge clk);
        if (!rst_n) begin
            t = 0; m_idle = 1; m_done = 0; m_err = 0; m_sbit = 0; m_start = 0;
            m_we = 0; m_addr = 0; m_in_done = 0; m_len = 0; m_cnt = 0;
        end
        check("ap_ctrl", {28'd0, ap_ctrl}, {28'd0, m_err, m_idle, m_done, m_sbit});
        check("data_length", data_length, m_len);
        check("out_cnt", out_cnt, m_cnt);
        check("ap_start", 32'(ap_start), 32'(m_start));
        check("dram_clr_we", 32'(dram_clr_we), 32'(m_we));
        check("cfg_lock", 32'(cfg_lock), 32'(!m_idle));
        if (m_we) check("dram_clr_addr", 32'(dram_clr_addr), 32'(m_addr));
        if (dram_clr_we) begin
            if (!we_prev) first_addr = dram_clr_addr;
            last_addr = dram_clr_addr;
            clr_seen++;
        end
        we_prev = dram_clr_we;
        if (ap_start) start_seen++;
        if (rst_n) begin
            run    = !m_idle && t >= TN + 1;
            fin    = run && out_hs && out_last;
            in_old = m_in_done;
            if (m_idle && len_wr) m_len = len_wdata;
            if (run && axis_finish) m_in_done = 1;
            if (run && out_hs) m_cnt = m_cnt + 1;
            if (ctrl_rd) m_done = 0;
            if (fin) begin
                m_idle = 1; m_done = 1;
                m_err = (m_cnt != m_len) || !in_old;
            end else if (m_idle && ctrl_wr && ctrl_wdata[0]) begin
                m_idle = 0; t = 1; m_cnt = 0; m_err = 0; m_in_done = 0;
            end else if (!m_idle) t++;
            m_we    = !m_idle && t <= TN;
            m_addr  = 12'(4 * (t - 1));
            m_start = !m_idle && t == TN + 1;
            m_sbit  = m_we;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        ctrl_wr = 0; ctrl_wdata = 0; ctrl_rd = 0; len_wr = 0;
        axis_finish = 0; out_hs = 0; out_last = 0;
    endtask

    task automatic start_run();
        ctrl_wr = 1; ctrl_wdata = 1;
        step();
    endtask

    task automatic wait_start(input string name);
        for (int i = 0; i < 40 && !ap_start; i++) step();
        check(name, 32'(ap_start), 32'd1);
    endtask

    task automatic beats(input int n, input logic rd_last);
        for (int i = 0; i < n; i++) begin
            out_hs = 1; out_last = (i == n - 1); ctrl_rd = rd_last && (i == n - 1);
            step();
        end
    endtask

    initial begin
        int cs0, ss0;
        rst_n = 0; ctrl_wr = 0; ctrl_wdata = 0; ctrl_rd = 0; len_wr = 0; len_wdata = 0;
        axis_finish = 0; out_hs = 0; out_last = 0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ap_ctrl", {28'd0, ap_ctrl}, 32'h4);
        check("rst_ap_start", 32'(ap_start), 32'd0);
        check("rst_clr_we", 32'(dram_clr_we), 32'd0);
        rst_n = 1;
        step();

        len_wr = 1; len_wdata = 64;
        step();
        cs0 = clr_seen; ss0 = start_seen;
        start_run();
        check("clear_ap_ctrl", {28'd0, ap_ctrl}, 32'h1);
        check("clear_lock", 32'(cfg_lock), 32'd1);
        ctrl_wr = 1; ctrl_wdata = 1; len_wr = 1; len_wdata = 5;
        step();
        wait_start("start1_seen");
        check("start1_ap_ctrl", {28'd0, ap_ctrl}, 32'h0);
        ctrl_wr = 1; ctrl_wdata = 1; len_wr = 1; len_wdata = 5;
        step();
        check("start1_one_cycle", 32'(ap_start), 32'd0);
        check("len_locked", data_length, 32'd64);
        check("run_lock", 32'(cfg_lock), 32'd1);
        step();
        check("clr1_count", 32'(clr_seen - cs0), 32'd11);
        check("clr1_first", 32'(first_addr), 32'h0);
        check("clr1_last", 32'(last_addr), 32'h28);

        axis_finish = 1;
        step();
        beats(64, 1'b0);
        check("run1_ap_ctrl", {28'd0, ap_ctrl}, 32'h6);
        check("run1_out_cnt", out_cnt, 32'd64);
        check("run1_unlock", 32'(cfg_lock), 32'd0);
        check("run1_one_start", 32'(start_seen - ss0), 32'd1);
        ctrl_rd = 1;
        step();
        check("rd_clears_done", {28'd0, ap_ctrl}, 32'h4);

        start_run();
        wait_start("start2_seen");
        axis_finish = 1;
        step();
        beats(10, 1'b1);
        check("run2_err_done", {28'd0, ap_ctrl}, 32'hE);
        check("run2_out_cnt", out_cnt, 32'd10);

        ctrl_rd = 1; ctrl_wr = 1; ctrl_wdata = 1;
        step();
        check("b2b_ap_ctrl", {28'd0, ap_ctrl}, 32'h1);
        check("b2b_out_cnt", out_cnt, 32'd0);
        for (int i = 0; i < 20 && !(dram_clr_we && dram_clr_addr == 12'h014); i++) step();
        check("clr_k5", 32'(dram_clr_addr), 32'h14);
        rst_n = 0;
        #1;
        check("arst_ap_ctrl", {28'd0, ap_ctrl}, 32'h4);
        check("arst_clr_we", 32'(dram_clr_we), 32'd0);
        check("arst_lock", 32'(cfg_lock), 32'd0);
        check("arst_len", data_length, 32'd0);
        step();
        step();
        rst_n = 1;
        step();

        len_wr = 1; len_wdata = 3;
        step();
        cs0 = clr_seen; ss0 = start_seen;
        start_run();
        wait_start("start3_seen");
        step();
        check("clr3_count", 32'(clr_seen - cs0), 32'd11);
        check("clr3_first", 32'(first_addr), 32'h0);
        axis_finish = 1;
        step();
        beats(3, 1'b0);
        check("run3_ap_ctrl", {28'd0, ap_ctrl}, 32'h6);
        check("run3_out_cnt", out_cnt, 32'd3);
        step();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
